// File: rtl/mont_mul_radix2.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-DATA_WIDTH mod MODULUS.
// One multiplier bit per cycle (LSB first), then one conditional final subtraction.
module mont_mul_radix2 #(
  parameter int                    DATA_WIDTH = 448,
  parameter logic [DATA_WIDTH-1:0] MODULUS    = {{223{1'b1}}, 1'b0, {224{1'b1}}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  localparam int SW = DATA_WIDTH + 2;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, REDUCE, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   a_sr;
  logic [DATA_WIDTH-1:0]   b_reg;
  logic [SW-1:0]           s_acc;
  logic [CW-1:0]           cnt;

  // S stays below 2*MODULUS, so S + B + MODULUS < 4*MODULUS fits in SW bits.
  function automatic logic [SW-1:0] mont_step(input logic [SW-1:0]         s,
                                               input logic                  a0,
                                               input logic [DATA_WIDTH-1:0] bv);
    logic [SW-1:0] t;
    t = s + (a0 ? {2'b00, bv} : {SW{1'b0}});
    if (t[0]) t = t + {2'b00, MODULUS};
    return t >> 1;
  endfunction

  function automatic logic [SW-1:0] final_sub(input logic [SW-1:0] s);
    logic [SW-1:0] m;
    m = {2'b00, MODULUS};
    return (s >= m) ? (s - m) : s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = REDUCE;
      end
      REDUCE: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        busy = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr      <= '0;
      b_reg     <= '0;
      s_acc     <= '0;
      cnt       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_reg <= b;
            s_acc <= '0;
            cnt   <= '0;
          end
        end
        ITER: begin
          s_acc <= mont_step(s_acc, a_sr[0], b_reg);
          a_sr  <= a_sr >> 1;
          cnt   <= cnt + 1'b1;
        end
        REDUCE: begin
          result    <= DATA_WIDTH'(final_sub(s_acc));
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule
